// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RV32I core: sequences fetch, decode, execute,
// memory and writeback, and decodes the datapath strobes from the current state.
module multicycle_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        branch_cond,
    input  logic        mem_ready,
    input  logic        halt_req,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] retired_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6,
        S_UNUSED = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t cur;
    logic   is_load;
    logic   is_store;
    logic   is_branch;
    logic   is_jal;
    logic   is_jalr;
    logic   is_alu;
    logic   legal;
    logic   retire;

    always_comb begin
        is_load   = (opcode == OP_LOAD);
        is_store  = (opcode == OP_STORE);
        is_branch = (opcode == OP_BRANCH);
        is_jal    = (opcode == OP_JAL);
        is_jalr   = (opcode == OP_JALR);
        is_alu    = (opcode == OP_R) || (opcode == OP_I) ||
                    (opcode == OP_LUI) || (opcode == OP_AUIPC);
        legal     = is_alu || is_jal ||
                    (is_load   && (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
                    (is_store  && (funct3 inside {3'b000, 3'b001, 3'b010})) ||
                    (is_branch && !(funct3 inside {3'b010, 3'b011})) ||
                    (is_jalr   && (funct3 == 3'b000));
    end

    // Strobes are pure decode of the present state; reset masks them all so an
    // in-flight memory request is dropped immediately.
    always_comb begin
        pc_write  = 1'b0;
        pc_src    = 2'b00;
        ir_write  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        retire    = 1'b0;
        if (!rst) begin
            case (cur)
                S_FETCH: begin
                    if (!halt_req) begin
                        mem_req  = 1'b1;
                        ir_write = mem_ready;
                    end
                end
                S_EXEC: begin
                    if (is_branch) begin
                        pc_write = 1'b1;
                        pc_src   = branch_cond ? 2'b01 : 2'b00;
                        retire   = 1'b1;
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = is_store;
                    if (is_store && mem_ready) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    if (is_load)
                        wb_sel = 2'b01;
                    else if (is_jal || is_jalr)
                        wb_sel = 2'b10;
                    if (is_jal)
                        pc_src = 2'b01;
                    else if (is_jalr)
                        pc_src = 2'b10;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur           <= S_FETCH;
            illegal       <= 1'b0;
            retired_count <= 32'd0;
        end else begin
            if (retire)
                retired_count <= retired_count + 32'd1;
            case (cur)
                S_FETCH: begin
                    if (halt_req)
                        cur <= S_HALT;
                    else if (mem_ready)
                        cur <= S_DECODE;
                end
                S_DECODE: begin
                    if (legal) begin
                        cur <= S_EXEC;
                    end else begin
                        cur     <= S_TRAP;
                        illegal <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_load || is_store)
                        cur <= S_MEM;
                    else if (is_branch)
                        cur <= S_FETCH;
                    else
                        cur <= S_WB;
                end
                S_MEM: begin
                    if (mem_ready)
                        cur <= is_store ? S_FETCH : S_WB;
                end
                S_WB:     cur <= S_FETCH;
                S_HALT: begin
                    if (!halt_req)
                        cur <= S_FETCH;
                end
                S_TRAP:   cur <= S_TRAP;
                default:  cur <= S_FETCH;
            endcase
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed per-cycle vector table followed by a
// randomized run against an instruction-path reference model.
module tb_multicycle_control;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        branch_cond;
    logic        mem_ready;
    logic        halt_req;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        ir_write;
    logic        mem_req;
    logic        mem_we;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic        illegal;
    logic [31:0] retired_count;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .branch_cond(branch_cond), .mem_ready(mem_ready), .halt_req(halt_req),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_req(mem_req), .mem_we(mem_we), .reg_write(reg_write),
        .wb_sel(wb_sel), .state(state), .illegal(illegal),
        .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe bundle {pc_write, pc_src, ir_write, mem_req, mem_we, reg_write, wb_sel}
    typedef struct packed {
        logic [8:0]  sb;
        logic [2:0]  st;
        logic        ill;
        logic [31:0] cnt;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       bc;
        logic       mr;
        logic       halt;
        outs_t      exp;
    } vec_t;

    localparam logic [6:0] R    = 7'b0110011;
    localparam logic [6:0] LD   = 7'b0000011;
    localparam logic [6:0] ST   = 7'b0100011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] BAD  = 7'b1111111;

    localparam logic [8:0] NONE    = 9'b0_00_0_0_0_0_00;
    localparam logic [8:0] FET     = 9'b0_00_1_1_0_0_00;
    localparam logic [8:0] RDREQ   = 9'b0_00_0_1_0_0_00;
    localparam logic [8:0] WRWAIT  = 9'b0_00_0_1_1_0_00;
    localparam logic [8:0] WRDONE  = 9'b1_00_0_1_1_0_00;
    localparam logic [8:0] WB_ALU  = 9'b1_00_0_0_0_1_00;
    localparam logic [8:0] WB_LD   = 9'b1_00_0_0_0_1_01;
    localparam logic [8:0] WB_JAL  = 9'b1_01_0_0_0_1_10;
    localparam logic [8:0] WB_JALR = 9'b1_10_0_0_0_1_10;
    localparam logic [8:0] BR_T    = 9'b1_01_0_0_0_0_00;
    localparam logic [8:0] BR_N    = 9'b1_00_0_0_0_0_00;

    localparam int CL_ILL = 0, CL_ALU = 1, CL_LOAD = 2, CL_STORE = 3,
                   CL_BRANCH = 4, CL_JAL = 5, CL_JALR = 6;

    int    checks = 0;
    int    errors = 0;
    vec_t  vecs[$];
    outs_t act;

    assign act = {pc_write, pc_src, ir_write, mem_req, mem_we, reg_write, wb_sel,
                  state, illegal, retired_count};

    int          m_state;
    logic        m_ill;
    logic [31:0] m_cnt;

    task automatic add_vec(input logic r, input logic [6:0] op, input logic [2:0] f3,
                           input logic bc, input logic mr, input logic halt,
                           input logic [2:0] st, input logic [8:0] sb,
                           input logic ill, input logic [31:0] cnt);
        vec_t v;
        v.rst = r; v.op = op; v.f3 = f3; v.bc = bc; v.mr = mr; v.halt = halt;
        v.exp = '{sb: sb, st: st, ill: ill, cnt: cnt};
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input logic r, input logic [6:0] op, input logic [2:0] f3,
                                  input logic bc, input logic mr, input logic halt);
        rst = r; opcode = op; funct3 = f3;
        branch_cond = bc; mem_ready = mr; halt_req = halt;
    endtask

    task automatic check_output(input string name, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got sb=%b st=%0d ill=%b cnt=%0d, want sb=%b st=%0d ill=%b cnt=%0d",
                     name, act.sb, act.st, act.ill, act.cnt, exp.sb, exp.st, exp.ill, exp.cnt);
        end
    endtask

    function automatic int classify(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return CL_ALU;
            7'b1101111: return CL_JAL;
            7'b0000011: return (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) ? CL_LOAD : CL_ILL;
            7'b0100011: return (f3 <= 2) ? CL_STORE : CL_ILL;
            7'b1100011: return (f3 == 2 || f3 == 3) ? CL_ILL : CL_BRANCH;
            7'b1100111: return (f3 == 0) ? CL_JALR : CL_ILL;
            default:    return CL_ILL;
        endcase
    endfunction

    // Expected outputs from the behaviour table of each phase of an instruction.
    function automatic outs_t expect_out(input int cls, input logic r, input logic bc,
                                         input logic mr, input logic halt);
        outs_t o;
        logic pcw, irw, mreq, mwe, rw;
        logic [1:0] pcs, wbs;
        pcw = 0; irw = 0; mreq = 0; mwe = 0; rw = 0; pcs = 0; wbs = 0;
        if (!r) begin
            if (m_state == 0 && !halt) begin
                mreq = 1; irw = mr;
            end else if (m_state == 2 && cls == CL_BRANCH) begin
                pcw = 1; pcs = bc ? 2'd1 : 2'd0;
            end else if (m_state == 3) begin
                mreq = 1; mwe = (cls == CL_STORE);
                pcw = (cls == CL_STORE) && mr;
            end else if (m_state == 4) begin
                rw = 1; pcw = 1;
                wbs = (cls == CL_LOAD) ? 2'd1 : (cls == CL_JAL || cls == CL_JALR) ? 2'd2 : 2'd0;
                pcs = (cls == CL_JAL) ? 2'd1 : (cls == CL_JALR) ? 2'd2 : 2'd0;
            end
        end
        o.sb  = {pcw, pcs, irw, mreq, mwe, rw, wbs};
        o.st  = 3'(m_state);
        o.ill = m_ill;
        o.cnt = m_cnt;
        return o;
    endfunction

    // Advance along the instruction's phase list; leaving the last phase retires it.
    task automatic model_step(input int cls, input logic r, input logic mr, input logic halt);
        int path[$];
        int idx;
        if (r) begin
            m_state = 0; m_ill = 0; m_cnt = 0;
            return;
        end
        case (m_state)
            0: m_state = halt ? 5 : (mr ? 1 : 0);
            1: begin
                if (cls == CL_ILL) begin
                    m_state = 6; m_ill = 1;
                end else begin
                    m_state = 2;
                end
            end
            5: m_state = halt ? 5 : 0;
            6: m_state = 6;
            default: begin
                path = '{0, 1, 2};
                if (cls == CL_LOAD || cls == CL_STORE) path.push_back(3);
                if (cls != CL_BRANCH && cls != CL_STORE) path.push_back(4);
                idx = 0;
                foreach (path[k]) if (path[k] == m_state) idx = k;
                if (m_state == 3 && !mr) begin
                    m_state = 3;
                end else if (idx == path.size() - 1) begin
                    m_state = 0;
                    m_cnt   = m_cnt + 1;
                end else begin
                    m_state = path[idx + 1];
                end
            end
        endcase
    endtask

    initial begin
        logic [6:0] r_op;
        logic [2:0] r_f3;
        logic       r_rst, r_bc, r_mr, r_halt;
        int         cls;

        apply_stimulus(1, R, 0, 0, 1, 0);
        @(posedge clk); #1;

        add_vec(1, R, 0, 0, 1, 0, 0, NONE, 0, 0);
        add_vec(0, R, 0, 0, 1, 0, 0, FET, 0, 0);
        add_vec(0, R, 0, 0, 1, 0, 1, NONE, 0, 0);
        add_vec(0, R, 0, 0, 1, 0, 2, NONE, 0, 0);
        add_vec(0, R, 0, 0, 1, 0, 4, WB_ALU, 0, 0);
        add_vec(0, LD, 2, 0, 1, 0, 0, FET, 0, 1);
        add_vec(0, LD, 2, 0, 0, 0, 1, NONE, 0, 1);
        add_vec(0, LD, 2, 0, 0, 0, 2, NONE, 0, 1);
        for (int i = 0; i < 3; i++) add_vec(0, LD, 2, 0, 0, 0, 3, RDREQ, 0, 1);
        add_vec(0, LD, 2, 0, 1, 0, 3, RDREQ, 0, 1);
        add_vec(0, LD, 2, 0, 1, 0, 4, WB_LD, 0, 1);
        add_vec(0, BR, 0, 1, 1, 0, 0, FET, 0, 2);
        add_vec(0, BR, 0, 1, 1, 0, 1, NONE, 0, 2);
        add_vec(0, BR, 0, 1, 1, 0, 2, BR_T, 0, 2);
        add_vec(0, BR, 0, 0, 1, 0, 0, FET, 0, 3);
        add_vec(0, BR, 0, 0, 1, 0, 1, NONE, 0, 3);
        add_vec(0, BR, 0, 0, 1, 0, 2, BR_N, 0, 3);
        add_vec(0, ST, 2, 0, 1, 0, 0, FET, 0, 4);
        add_vec(0, ST, 2, 0, 1, 0, 1, NONE, 0, 4);
        add_vec(0, ST, 2, 0, 1, 0, 2, NONE, 0, 4);
        add_vec(0, ST, 2, 0, 0, 0, 3, WRWAIT, 0, 4);
        add_vec(0, ST, 2, 0, 1, 0, 3, WRDONE, 0, 4);
        add_vec(0, JAL, 0, 0, 1, 0, 0, FET, 0, 5);
        add_vec(0, JAL, 0, 0, 1, 0, 1, NONE, 0, 5);
        add_vec(0, JAL, 0, 0, 1, 0, 2, NONE, 0, 5);
        add_vec(0, JAL, 0, 0, 1, 0, 4, WB_JAL, 0, 5);
        add_vec(0, JALR, 0, 0, 1, 0, 0, FET, 0, 6);
        add_vec(0, JALR, 0, 0, 1, 0, 1, NONE, 0, 6);
        add_vec(0, JALR, 0, 0, 1, 0, 2, NONE, 0, 6);
        add_vec(0, JALR, 0, 0, 1, 0, 4, WB_JALR, 0, 6);
        add_vec(0, R, 0, 0, 1, 1, 0, NONE, 0, 7);
        add_vec(0, R, 0, 0, 1, 1, 5, NONE, 0, 7);
        add_vec(0, R, 0, 0, 1, 0, 5, NONE, 0, 7);
        add_vec(0, BAD, 0, 0, 1, 0, 0, FET, 0, 7);
        add_vec(0, BAD, 0, 0, 1, 0, 1, NONE, 0, 7);
        for (int i = 0; i < 10; i++)
            add_vec(0, BAD, 0, i[0], i[1], i[2], 6, NONE, 1, 7);
        add_vec(1, BAD, 0, 0, 1, 0, 6, NONE, 1, 7);
        add_vec(0, ST, 2, 0, 1, 0, 0, FET, 0, 0);
        add_vec(0, ST, 2, 0, 1, 0, 1, NONE, 0, 0);
        add_vec(0, ST, 2, 0, 1, 0, 2, NONE, 0, 0);
        add_vec(0, ST, 2, 0, 0, 0, 3, WRWAIT, 0, 0);
        add_vec(1, ST, 2, 0, 0, 0, 3, NONE, 0, 0);
        add_vec(0, ST, 2, 0, 0, 0, 0, RDREQ, 0, 0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rst, vecs[i].op, vecs[i].f3,
                           vecs[i].bc, vecs[i].mr, vecs[i].halt);
            @(negedge clk);
            check_output($sformatf("vec%0d", i), vecs[i].exp);
            @(posedge clk); #1;
        end

        apply_stimulus(1, R, 0, 0, 1, 0);
        @(posedge clk); #1;
        m_state = 0; m_ill = 0; m_cnt = 0;
        r_op = R; r_f3 = 0;

        for (int n = 0; n < 3000; n++) begin
            if (m_state == 0) begin
                case ($urandom_range(0, 9))
                    0: r_op = R;
                    1: r_op = 7'b0010011;
                    2: r_op = 7'b0110111;
                    3: r_op = 7'b0010111;
                    4: r_op = JAL;
                    5: r_op = JALR;
                    6: r_op = LD;
                    7: r_op = ST;
                    8: r_op = BR;
                    default: r_op = 7'($urandom);
                endcase
                r_f3 = 3'($urandom);
                if (r_op == JALR && $urandom_range(0, 1) == 0) r_f3 = 0;
            end
            r_rst  = ($urandom_range(0, 99) == 0) ||
                     (m_state == 6 && $urandom_range(0, 3) == 0);
            r_bc   = 1'($urandom);
            r_mr   = ($urandom_range(0, 3) != 0);
            r_halt = ($urandom_range(0, 15) == 0);
            cls    = classify(r_op, r_f3);
            apply_stimulus(r_rst, r_op, r_f3, r_bc, r_mr, r_halt);
            @(negedge clk);
            check_output($sformatf("rand%0d", n), expect_out(cls, r_rst, r_bc, r_mr, r_halt));
            @(posedge clk); #1;
            model_step(cls, r_rst, r_mr, r_halt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL: opcode  input  7  instruction[6:0] from instruction register.
REQ-004 SHALL: funct3  input  3  instruction[14:12] from instruction register.
REQ-005 SHALL: branch_cond  input  1  branch comparison result, 1 = taken.
REQ-006 SHALL: mem_ready  input  1  memory completes the pending access this cycle.
REQ-007 SHALL: halt_req  input  1  request to stop fetching.
REQ-008 SHALL: pc_write  output  1  PC register load strobe.
REQ-009 SHALL: pc_src  output  2  next-PC select: 00 sequential, 01 branch/JAL target, 10 JALR target.
REQ-010 SHALL: ir_write  output  1  instruction register load strobe.
REQ-011 SHALL: mem_req  output  1  memory access request, held until mem_ready.
REQ-012 SHALL: mem_we  output  1  write qualifier for mem_req.
REQ-013 SHALL: reg_write  output  1  register file write strobe.
REQ-014 SHALL: wb_sel  output  2  writeback source: 00 ALU, 01 memory, 10 sequential PC.
REQ-015 SHALL: state  output  3  current FSM state encoding.
REQ-016 SHALL: illegal  output  1  sticky illegal-instruction flag.
REQ-017 SHALL: retired_count  output  32  retired instruction counter.

Function
REQ-018 SHALL: states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6; encoding 7 unreachable and SHALL map to FETCH on the next edge.
REQ-019 SHALL: all strobes (pc_write, ir_write, mem_req, mem_we, reg_write) decode combinationally from state, opcode, funct3, branch_cond, mem_ready and halt_req; they SHALL be 0 in any state or condition not listed below; pc_src and wb_sel SHALL be 00 when not specified.
REQ-020 SHALL: FETCH with halt_req=1: mem_req=0, next state HALT; halt_req has priority over mem_ready.
REQ-021 SHALL: FETCH with halt_req=0: mem_req=1, mem_we=0; stays in FETCH while mem_ready=0; on mem_ready=1: ir_write=1, next state DECODE.
REQ-022 SHALL: DECODE lasts exactly one cycle; next state EXEC if the instruction is legal, else TRAP.
REQ-023 SHALL: legal = opcode in {0110011, 0010011, 0110111, 0010111, 1101111}; or 0000011 with funct3 in {000,001,010,100,101}; or 0100011 with funct3 in {000,001,010}; or 1100011 with funct3 not in {010,011}; or 1100111 with funct3=000.
REQ-024 SHALL: EXEC for load/store goes to MEM; for branch asserts pc_write=1, pc_src=01 if branch_cond=1 else 00, retires, and goes to FETCH; for all other legal opcodes goes to WB.
REQ-025 SHALL: MEM asserts mem_req=1 (mem_we=1 for store) until mem_ready=1; a load then goes to WB; a store asserts pc_write=1, pc_src=00, retires, and goes to FETCH.
REQ-026 SHALL: WB asserts reg_write=1 and pc_write=1 for exactly one cycle, retires, and goes to FETCH; wb_sel=01 for load, 10 for JAL/JALR, else 00; pc_src=01 for JAL, 10 for JALR, else 00.
REQ-027 SHALL: mem_ready SHALL be ignored outside FETCH and MEM.
REQ-028 SHALL: HALT holds all strobes 0 while halt_req=1 and returns to FETCH the cycle after halt_req=0 is sampled.
REQ-029 SHALL: on entering TRAP, illegal is set to 1; TRAP holds all strobes 0 and is exited only by rst.
REQ-030 SHALL: retired_count increments by 1 on the edge ending each retiring cycle (REQ-024/025/026), wraps 0xFFFFFFFF to 0, and never increments on a trapped instruction.
REQ-031 SHALL: CPI with mem_ready always 1: branch 3, store 4, R/I/LUI/AUIPC/JAL/JALR 4, load 5 cycles.

Reset
REQ-032 SHALL: rst=1 at an edge sets state=FETCH, illegal=0, retired_count=0, regardless of current state, including mid-MEM or mid-FETCH.
REQ-033 SHALL: while rst=1, all strobes are forced to 0; the pending memory request is abandoned with no retire.

Verification
REQ-034 SHALL: reset, then mem_ready=1, opcode=0110011 -> states 0,1,2,4,0; reg_write=1 and pc_write=1 in state 4 only; retired_count=1 after 4 cycles.
REQ-035 SHALL: load (0000011, funct3=010), mem_ready low for 3 MEM cycles -> mem_req held 4 cycles in MEM; WB wb_sel=01; 8 cycles total.
REQ-036 SHALL: branch (1100011, funct3=000) with branch_cond=1 then 0 -> EXEC pc_src=01 then 00; pc_write=1 both times; retired_count=2.
REQ-037 SHALL: opcode=1111111 -> DECODE to TRAP; illegal=1; strobes 0 for 10 cycles; retired_count unchanged; rst clears illegal to 0.
REQ-038 SHALL: halt_req=1 in FETCH with mem_ready=1 -> mem_req=0, ir_write=0, state=5; halt_req=0 -> state 0 next cycle.
REQ-039 SHALL: rst asserted in MEM of a store with mem_ready=0 -> next state 0, mem_we=0 during reset, retired_count=0.
